// File: rtl/lc3_alu_pipe_if.sv
// Request/result handshake bundle for the lc3_alu_pipe execute stage.
// The master is the issuing side; the slave is the ALU.
interface lc3_alu_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_nzp;
    logic             out_ovf;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_nzp, out_ovf
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_nzp, out_ovf
    );
endinterface

// File: rtl/lc3_alu_pipe.sv
// Registered LC-3 execute-stage ALU: single-cycle logic/arith/shift ops,
// iterative shift-add multiply, NZP and signed-add overflow flags.
module lc3_alu_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    lc3_alu_pipe_if.slave bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_AND = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SHL = 3'd5;
    localparam logic [2:0] OP_SRA = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    typedef enum logic [0:0] {S_IDLE, S_MUL} state_e;

    state_e             state_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   acc_q;
    logic [SHW-1:0]     cnt_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_result_q;
    logic [2:0]         out_nzp_q;
    logic               out_ovf_q;

    logic               accept;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   sum;
    logic signed [WIDTH-1:0] a_s;
    logic [WIDTH-1:0]   alu_res_d;
    logic               alu_ovf_d;
    logic [WIDTH-1:0]   acc_d;

    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] r);
        return {r[WIDTH-1], r == '0, ~r[WIDTH-1] & (r != '0)};
    endfunction

    // A consumed result frees the slot in the same cycle.
    assign bus.in_ready = ~rst & (state_q == S_IDLE) & (~out_valid_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;

    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_nzp    = out_nzp_q;
    assign bus.out_ovf    = out_ovf_q;

    // Single-cycle op datapath, evaluated on the live request.
    always_comb begin
        alu_res_d = '0;
        alu_ovf_d = 1'b0;
        shamt     = bus.in_b[SHW-1:0];
        sum       = bus.in_a + bus.in_b;
        a_s       = bus.in_a;
        case (bus.in_op)
            OP_ADD: begin
                alu_res_d = sum;
                alu_ovf_d = (bus.in_a[WIDTH-1] == bus.in_b[WIDTH-1]) &
                            (sum[WIDTH-1] != bus.in_a[WIDTH-1]);
            end
            OP_AND:  alu_res_d = bus.in_a & bus.in_b;
            OP_NOT:  alu_res_d = ~bus.in_a;
            OP_OR:   alu_res_d = bus.in_a | bus.in_b;
            OP_XOR:  alu_res_d = bus.in_a ^ bus.in_b;
            OP_SHL:  alu_res_d = bus.in_a << shamt;
            OP_SRA:  alu_res_d = a_s >>> shamt;
            default: alu_res_d = '0;
        endcase
    end

    assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_nzp_q    <= 3'b010;
            out_ovf_q    <= 1'b0;
        end else begin
            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (bus.in_op == OP_MUL) begin
                            mcand_q  <= bus.in_a;
                            mplier_q <= bus.in_b;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            state_q  <= S_MUL;
                        end else begin
                            out_result_q <= alu_res_d;
                            out_nzp_q    <= nzp_of(alu_res_d);
                            out_ovf_q    <= alu_ovf_d;
                            out_valid_q  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    // One shift-add step per cycle; the last step writes the output.
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + SHW'(1);
                    if (cnt_q == SHW'(WIDTH - 1)) begin
                        out_result_q <= acc_d;
                        out_nzp_q    <= nzp_of(acc_d);
                        out_ovf_q    <= 1'b0;
                        out_valid_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lc3_alu_pipe.sv
// Directed bench for lc3_alu_pipe at WIDTH=16 plus a WIDTH=8 multiply instance.
module tb_lc3_alu_pipe;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   n;
    logic saw_valid;

    lc3_alu_pipe_if #(.WIDTH(16)) bus  ();
    lc3_alu_pipe_if #(.WIDTH(8))  bus8 ();

    lc3_alu_pipe #(.WIDTH(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
    lc3_alu_pipe #(.WIDTH(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
    endtask

    task automatic chk_out(input string tag, input logic [15:0] res, input logic [2:0] nzp,
                           input logic ovf);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_res"},   32'(bus.out_result), 32'(res));
        chk({tag, "_nzp"},   32'(bus.out_nzp), 32'(nzp));
        chk({tag, "_ovf"},   32'(bus.out_ovf), 32'(ovf));
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_a = '0; bus.in_b = '0; bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0; bus8.in_op = 3'd0; bus8.in_a = '0; bus8.in_b = '0; bus8.out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_valid",    32'(bus.out_valid), 32'd0);
        chk("rst_res",      32'(bus.out_result), 32'd0);
        chk("rst_nzp",      32'(bus.out_nzp), 32'b010);
        chk("rst_ovf",      32'(bus.out_ovf), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Back-to-back basic ops
        drive(3'd0, 16'h0003, 16'h0004); tick(); chk_out("add", 16'h0007, 3'b001, 1'b0);
        chk("add_in_ready", 32'(bus.in_ready), 32'd1);
        drive(3'd1, 16'hF0F0, 16'h0FF0); tick(); chk_out("and", 16'h00F0, 3'b001, 1'b0);
        drive(3'd2, 16'h00FF, 16'h1234); tick(); chk_out("not", 16'hFF00, 3'b100, 1'b0);
        drive(3'd3, 16'h0000, 16'h0000); tick(); chk_out("or",  16'h0000, 3'b010, 1'b0);

        // Overflow and wrap
        drive(3'd0, 16'h7FFF, 16'h0001); tick(); chk_out("add_ovf",  16'h8000, 3'b100, 1'b1);
        drive(3'd0, 16'hFFFF, 16'h0001); tick(); chk_out("add_wrap", 16'h0000, 3'b010, 1'b0);

        // Shifts and xor
        drive(3'd5, 16'h0001, 16'h0013); tick(); chk_out("shl", 16'h0008, 3'b001, 1'b0);
        drive(3'd6, 16'h8000, 16'h000F); tick(); chk_out("sra_neg", 16'hFFFF, 3'b100, 1'b0);
        drive(3'd6, 16'h4000, 16'h0000); tick(); chk_out("sra_0", 16'h4000, 3'b001, 1'b0);
        drive(3'd5, 16'hC001, 16'h0001); tick(); chk_out("shl_drop", 16'h8002, 3'b100, 1'b0);
        drive(3'd4, 16'hFFFF, 16'h0F0F); tick(); chk_out("xor", 16'hF0F0, 3'b100, 1'b0);

        // Consumed with no accept: valid drops, registers hold
        bus.in_valid = 1'b0;
        tick();
        chk("idle_valid", 32'(bus.out_valid), 32'd0);
        chk("idle_hold",  32'(bus.out_result), 32'h0000F0F0);

        // Multiply, exact latency and in_ready low throughout
        drive(3'd7, 16'h0012, 16'h0034);
        tick();
        bus.in_valid = 1'b0;
        bus.in_a = 16'hFFFF;
        saw_valid = 1'b0;
        for (int i = 1; i < 16; i++) begin
            if (bus.in_ready || bus.out_valid) saw_valid = 1'b1;
            tick();
        end
        chk("mul_busy", 32'(saw_valid), 32'd0);
        chk("mul_ready_last", 32'(bus.in_ready), 32'd0);
        tick();
        chk_out("mul", 16'h03A8, 3'b001, 1'b0);

        drive(3'd7, 16'hFFFF, 16'hFFFF);
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin tick(); n++; end
        chk("mul_ff_lat", 32'(n), 32'd16);
        chk_out("mul_ff", 16'h0001, 3'b001, 1'b0);

        drive(3'd7, 16'h0000, 16'h1234);
        tick();
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin tick(); n++; end
        chk("mul_zero_lat", 32'(n), 32'd16);
        chk_out("mul_zero", 16'h0000, 3'b010, 1'b0);

        // Backpressure
        tick();
        bus.out_ready = 1'b0;
        drive(3'd0, 16'h0001, 16'h0002);
        tick();
        bus.in_valid = 1'b0;
        chk_out("bp_add", 16'h0003, 3'b001, 1'b0);
        drive(3'd0, 16'h1111, 16'h1111);
        saw_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus.in_ready || !bus.out_valid || bus.out_result != 16'h0003) saw_valid = 1'b1;
        end
        chk("bp_stall", 32'(saw_valid), 32'd0);
        bus.out_ready = 1'b1;
        drive(3'd4, 16'h00FF, 16'h0F0F);
        #1;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk_out("bp_xor", 16'h0FF0, 3'b001, 1'b0);

        // Reset in the middle of a multiply
        tick();
        drive(3'd7, 16'h0003, 16'h0005);
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("rmul_valid", 32'(bus.out_valid), 32'd0);
        chk("rmul_res",   32'(bus.out_result), 32'd0);
        chk("rmul_nzp",   32'(bus.out_nzp), 32'b010);
        chk("rmul_ready", 32'(bus.in_ready), 32'd1);
        saw_valid = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.out_valid) saw_valid = 1'b1;
        end
        chk("rmul_no_stale", 32'(saw_valid), 32'd0);

        // WIDTH=8 multiply
        bus8.in_valid = 1'b1; bus8.in_op = 3'd7; bus8.in_a = 8'h0F; bus8.in_b = 8'h11;
        tick();
        bus8.in_valid = 1'b0;
        n = 0;
        while (!bus8.out_valid && n < 40) begin tick(); n++; end
        chk("mul8_lat", 32'(n), 32'd8);
        chk("mul8_res", 32'(bus8.out_result), 32'h000000FF);
        chk("mul8_nzp", 32'(bus8.out_nzp), 32'b100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
